// File: rtl/risc_pkg.sv
// Shared definitions for the writeback path: widths, load-size encodings,
// the writeback FSM state type and the byte/half extension helper.
package risc_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    // Bytes arrive in v[7:0]; the fill bit comes from the top bit of the used field.
    function automatic logic [DATA_W-1:0] extend_sub(input logic [15:0] v,
                                                     input logic        is_byte,
                                                     input logic        zero_ext);
        logic sign_bit;
        logic fill;
        sign_bit = is_byte ? v[7] : v[15];
        fill     = ~zero_ext & sign_bit;
        if (is_byte) begin
            return {{24{fill}}, v[7:0]};
        end
        return {{16{fill}}, v};
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word from an aligned memory word and
// sign- or zero-extends it to the register width.
module load_align
    import risc_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_offset,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_byte  = i_rdata[7:0];
        w_half  = i_rdata[15:0];
        o_value = i_rdata;

        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase

        // Halfword offset ignores bit 0: a misaligned half reads its containing half.
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_BYTE: o_value = extend_sub({8'h00, w_byte}, 1'b1, i_unsigned);
            SZ_HALF: o_value = extend_sub(w_half, 1'b0, i_unsigned);
            SZ_WORD: o_value = i_rdata;
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: ALU results retire in one cycle, loads wait
// for memory data with a timeout. Optional macro WB_SCOREBOARD_EN adds busy/busy_rd.
module writeback_unit
    import risc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_is_load,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] write_reg,
    output logic [DATA_W-1:0]    write_data,
    output logic                 load_err
`ifdef WB_SCOREBOARD_EN
    ,
    output logic                 busy,
    output logic [REG_IDX_W-1:0] busy_rd
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    wb_state_e            r_state;
    logic [REG_IDX_W-1:0] r_rd;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [1:0]           r_offset;
    logic [CNT_W-1:0]     r_count;
    logic                 r_reg_write;
    logic [REG_IDX_W-1:0] r_write_reg;
    logic [DATA_W-1:0]    r_write_data;
    logic                 r_load_err;

    logic                 w_accept;
    logic [CNT_W-1:0]     w_count_next;
    logic [DATA_W-1:0]    w_load_value;

    assign in_ready     = (r_state == IDLE);
    assign w_accept     = in_valid & in_ready;
    assign w_count_next = r_count + CNT_W'(1);

    load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_value    (w_load_value)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd         <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_offset     <= '0;
            r_count      <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_load_err   <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_load_err  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_is_load) begin
                            r_rd       <= in_rd;
                            r_size     <= in_size;
                            r_unsigned <= in_unsigned;
                            r_offset   <= in_data[1:0];
                            r_count    <= '0;
                            r_state    <= WAIT_MEM;
                        end else begin
                            // Register 0 is hardwired: the index/data still move, the enable does not.
                            r_reg_write  <= (in_rd != '0);
                            r_write_reg  <= in_rd;
                            r_write_data <= in_data;
                        end
                    end
                end

                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_reg_write  <= (r_rd != '0);
                        r_write_reg  <= r_rd;
                        r_write_data <= w_load_value;
                        r_state      <= IDLE;
                    end else begin
                        r_count <= w_count_next;
                        if (w_count_next == TIMEOUT_CNT) begin
                            r_load_err <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign load_err   = r_load_err;

`ifdef WB_SCOREBOARD_EN
    assign busy    = (r_state == WAIT_MEM);
    assign busy_rd = (r_state == WAIT_MEM) ? r_rd : '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, table-driven bench for writeback_unit (built with TIMEOUT=4).
module tb_writeback_unit;
    import risc_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_is_load;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        load_err;
`ifdef WB_SCOREBOARD_EN
    logic        busy;
    logic [4:0]  busy_rd;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    writeback_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_data     (in_data),
        .in_is_load  (in_is_load),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .load_err    (load_err)
`ifdef WB_SCOREBOARD_EN
        ,
        .busy        (busy),
        .busy_rd     (busy_rd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } alu_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_data;
    } load_vec_t;

    alu_vec_t  alu_tab[5];
    load_vec_t load_tab[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_rd       = 5'h1f;
        in_data     = 32'hFFFF_FFFF;
        in_is_load  = 1'b0;
        in_size     = 2'b11;
        in_unsigned = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic accept_load(input logic [4:0] rd, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns);
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_rd       = rd;
        in_data     = addr;
        in_size     = size;
        in_unsigned = uns;
        check("ld_ready_before", 32'(in_ready), 32'd1);
        tick();
        idle_inputs();
        in_unsigned = ~uns;
        check("ld_ready_wait", 32'(in_ready), 32'd0);
        check("ld_no_write_accept", 32'(reg_write), 32'd0);
`ifdef WB_SCOREBOARD_EN
        check("ld_busy", 32'(busy), 32'd1);
        check("ld_busy_rd", 32'(busy_rd), 32'(rd));
`endif
    endtask

    task automatic do_load(input load_vec_t t);
        accept_load(t.rd, t.addr, t.size, t.uns);
        for (int c = 1; c < t.delay; c++) begin
            tick();
            check("ld_no_write_wait", 32'(reg_write), 32'd0);
            check("ld_ready_wait2", 32'(in_ready), 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = t.rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("ld_we", 32'(reg_write), 32'(t.exp_we));
        check("ld_rd", 32'(write_reg), 32'(t.rd));
        check("ld_data", write_data, t.exp_data);
        check("ld_no_err", 32'(load_err), 32'd0);
        check("ld_ready_done", 32'(in_ready), 32'd1);
`ifdef WB_SCOREBOARD_EN
        check("ld_busy_done", 32'(busy), 32'd0);
        check("ld_busy_rd_done", 32'(busy_rd), 32'd0);
`endif
        tick();
        check("ld_we_one_cycle", 32'(reg_write), 32'd0);
    endtask

    initial begin
        alu_tab[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF};
        alu_tab[1] = '{1'b1, 5'd0,  32'h0000_0001, 1'b0, 5'd0,  32'h0000_0001};
        alu_tab[2] = '{1'b0, 5'd7,  32'h1234_5678, 1'b0, 5'd0,  32'h0000_0001};
        alu_tab[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd31, 32'hA5A5_A5A5};
        alu_tab[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};

        load_tab[0] = '{5'd3,  32'h0000_1002, SZ_BYTE, 1'b0, 32'h1280_5634, 3, 1'b1, 32'hFFFF_FF80};
        load_tab[1] = '{5'd4,  32'h0000_0002, SZ_HALF, 1'b1, 32'h8001_FFFF, 1, 1'b1, 32'h0000_8001};
        load_tab[2] = '{5'd6,  32'h0000_0003, SZ_WORD, 1'b0, 32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D};
        load_tab[3] = '{5'd7,  32'h0000_0003, SZ_HALF, 1'b0, 32'h8001_FFFF, 1, 1'b1, 32'hFFFF_8001};
        load_tab[4] = '{5'd8,  32'h0000_0001, SZ_BYTE, 1'b1, 32'h1280_5634, 1, 1'b1, 32'h0000_0056};
        load_tab[5] = '{5'd9,  32'h0000_0000, SZ_HALF, 1'b0, 32'h0000_7FFF, 2, 1'b1, 32'h0000_7FFF};
        load_tab[6] = '{5'd0,  32'h0000_0000, SZ_WORD, 1'b0, 32'h1111_1111, 1, 1'b0, 32'h1111_1111};
        load_tab[7] = '{5'd10, 32'h0000_0000, 2'b11,   1'b1, 32'h8000_0001, 1, 1'b1, 32'h8000_0001};
        load_tab[8] = '{5'd11, 32'h0000_0003, SZ_BYTE, 1'b0, 32'h9A00_0000, 2, 1'b1, 32'hFFFF_FF9A};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU results, one per cycle.
        for (int i = 0; i < 5; i++) begin
            in_valid   = alu_tab[i].valid;
            in_rd      = alu_tab[i].rd;
            in_data    = alu_tab[i].data;
            in_is_load = 1'b0;
            tick();
            check($sformatf("alu%0d_we", i), 32'(reg_write), 32'(alu_tab[i].exp_we));
            check($sformatf("alu%0d_rd", i), 32'(write_reg), 32'(alu_tab[i].exp_rd));
            check($sformatf("alu%0d_data", i), write_data, alu_tab[i].exp_data);
            check($sformatf("alu%0d_ready", i), 32'(in_ready), 32'd1);
        end
        idle_inputs();
        tick();
        check("alu_we_drop", 32'(reg_write), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_load(load_tab[i]);
        end

        // Memory data with no outstanding load is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        check("idle_rvalid_we", 32'(reg_write), 32'd0);
        check("idle_rvalid_err", 32'(load_err), 32'd0);
        check("idle_rvalid_ready", 32'(in_ready), 32'd1);

        // Timeout: four waiting cycles without data abort the load.
        accept_load(5'd12, 32'h0, SZ_WORD, 1'b0);
        for (int c = 1; c < 4; c++) begin
            tick();
            check("to_no_err_yet", 32'(load_err), 32'd0);
            check("to_ready_wait", 32'(in_ready), 32'd0);
        end
        tick();
        check("to_err_pulse", 32'(load_err), 32'd1);
        check("to_no_write", 32'(reg_write), 32'd0);
        check("to_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("to_err_one_cycle", 32'(load_err), 32'd0);

        // Data arriving in the cycle the count reaches the limit wins.
        accept_load(5'd13, 32'h0, SZ_WORD, 1'b0);
        for (int c = 1; c < 4; c++) begin
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        check("race_we", 32'(reg_write), 32'd1);
        check("race_rd", 32'(write_reg), 32'd13);
        check("race_data", write_data, 32'h0BAD_F00D);
        check("race_no_err", 32'(load_err), 32'd0);
        tick();
        check("race_no_late_err", 32'(load_err), 32'd0);

        // Reset while a load is outstanding drops it.
        accept_load(5'd3, 32'h0, SZ_WORD, 1'b0);
        tick();
`ifdef WB_SCOREBOARD_EN
        check("rstw_busy_rd", 32'(busy_rd), 32'd3);
`endif
        rst_n = 1'b0;
        #1;
        check("rstw_ready", 32'(in_ready), 32'd1);
        check("rstw_we", 32'(reg_write), 32'd0);
        check("rstw_write_data", write_data, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        tick();
        rst_n = 1'b1;
        tick();
        check("rstw_post_we", 32'(reg_write), 32'd0);
        check("rstw_post_err", 32'(load_err), 32'd0);
        check("rstw_post_ready", 32'(in_ready), 32'd1);
        mem_rvalid = 1'b0;
        tick();
        check("rstw_post_we2", 32'(reg_write), 32'd0);

        in_valid = 1'b1;
        in_rd    = 5'd2;
        in_data  = 32'h0000_0055;
        tick();
        idle_inputs();
        check("after_rst_alu_we", 32'(reg_write), 32'd1);
        check("after_rst_alu_data", write_data, 32'h0000_0055);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 TIMEOUT, 255, max cycles waited for load data before abort; range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream result/load request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_data  input  32  ALU result, or load address when in_is_load=1.
REQ-008 in_is_load  input  1  request is a load awaiting memory data.
REQ-009 in_size  input  2  load size: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 in_unsigned  input  1  zero-extend byte/half loads when 1; sign-extend when 0.
REQ-011 mem_rvalid  input  1  load data valid, single-cycle pulse.
REQ-012 mem_rdata  input  32  aligned 32-bit memory word.
REQ-013 reg_write  output  1  register-file write enable.
REQ-014 write_reg  output  5  register-file write index.
REQ-015 write_data  output  32  register-file write data.
REQ-016 load_err  output  1  one-cycle pulse on load timeout.

Function
REQ-017 FSM SHALL have states IDLE and WAIT_MEM; in_ready SHALL be 1 only in IDLE.
REQ-018 Accept = in_valid & in_ready; nothing SHALL be captured without accept.
REQ-019 Non-load accept in IDLE: next cycle reg_write=1, write_reg=in_rd, write_data=in_data (latency 1); state stays IDLE; back-to-back accepts every cycle SHALL be supported.
REQ-020 Load accept in IDLE: capture in_rd, in_size, in_unsigned, in_data[1:0]; go to WAIT_MEM; clear timeout counter; no write this or next cycle.
REQ-021 In WAIT_MEM with mem_rvalid=1: next cycle reg_write=1, write_reg=captured rd, write_data=aligned load value; state returns to IDLE.
REQ-022 Alignment: byte = mem_rdata[8*off+7:8*off]; half = mem_rdata[16*off[1]+15:16*off[1]]; word = mem_rdata unchanged; off[0] SHALL be ignored for half and off ignored for word.
REQ-023 Extension: byte/half SHALL be sign-extended from their top bit unless captured in_unsigned=1.
REQ-024 Timeout counter SHALL be 8 bits and increment each WAIT_MEM cycle without mem_rvalid; reaching TIMEOUT SHALL pulse load_err for one cycle next cycle, return to IDLE, perform no write.
REQ-025 mem_rvalid in the same cycle the counter reaches TIMEOUT: data wins, write occurs, no load_err.
REQ-026 mem_rvalid while in IDLE SHALL be ignored.
REQ-027 Any write with index 0 SHALL drive reg_write=0; write_reg/write_data still update.
REQ-028 reg_write SHALL be 1 for exactly one cycle per completed request, otherwise 0.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, reg_write=0, write_reg=0, write_data=0, load_err=0, counter=0.
REQ-030 Reset during WAIT_MEM SHALL drop the outstanding load with no write and no load_err.
REQ-031 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-032 Macro WB_SCOREBOARD_EN, when defined, SHALL add outputs busy (1) and busy_rd (5): busy=1 and busy_rd=captured rd throughout WAIT_MEM, else busy=0, busy_rd=0.
REQ-033 Without WB_SCOREBOARD_EN those ports and their logic SHALL not exist; all other behaviour identical.

Structure
REQ-034 Shared package risc_pkg SHALL hold load-size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state typedef, and register index/data width constants.
REQ-035 Alignment/extension SHALL be a combinational sub-module load_align (inputs rdata, offset, size, unsigned; output 32-bit value).

Verification
REQ-036 ALU rd=5 data=0xDEADBEEF -> next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF.
REQ-037 Load rd=3 size=byte off=2 signed, mem_rdata=0x12805634 three cycles later -> write_data=0xFFFFFF80; in_ready=0 until done.
REQ-038 Load half unsigned off=2, mem_rdata=0x8001FFFF -> write_data=0x00008001; word load -> mem_rdata unchanged.
REQ-039 ALU rd=0 data=0x1 -> reg_write stays 0; TIMEOUT=4, no mem_rvalid -> load_err pulse, no write, back to IDLE.
REQ-040 rst_n low during WAIT_MEM, then mem_rvalid -> no write, in_ready=1 after release; with WB_SCOREBOARD_EN, busy_rd=3 while waiting.
